// File: rtl/rowbuf_pkg.sv
// rowbuf_pkg: state encoding, width helpers and pad constant
// shared by the RowBuf49 sequencer files.
package rowbuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  function automatic int rb_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DATA_WIDTH = 14;
  localparam int COL_W = rb_width(640);
  localparam int ROW_W = rb_width(480 + 3);

  localparam logic PAD_BIT = 1'b0;
  localparam logic [DATA_WIDTH-1:0] PAD_VALUE = '0;

endpackage

// File: rtl/rowbuf_seq_ctrl_raster_counter.sv
// raster_counter: col/row position with enable and sync clear.
// nxt_* and the flags describe the position after this cycle.
module raster_counter
  import rowbuf_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int CW           = 10,
  parameter int RW           = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [CW-1:0] nxt_col,
  output logic [RW-1:0] nxt_row,
  output logic          eol,
  output logic          eof
);

  localparam logic [CW-1:0] COL_END = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_END = RW'(IMAGE_HEIGHT - 1);

  always_comb begin
    nxt_col = col;
    nxt_row = row;
    if (clr) begin
      nxt_col = '0;
      nxt_row = '0;
    end else if (en) begin
      if (col == COL_END) begin
        nxt_col = '0;
        nxt_row = row + 1'b1;
      end else begin
        nxt_col = col + 1'b1;
      end
    end
  end

  assign eol = (nxt_col == COL_END);
  assign eof = eol && (nxt_row == ROW_END);

  always_ff @(posedge clk) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= nxt_col;
      row <= nxt_row;
    end
  end

endmodule

// File: rtl/rowbuf_seq_ctrl.sv
// rowbuf_seq_ctrl: raster sequencer driving the RowBuf49 shift enable.
// Define ROWBUF_CTRL_FLUSH_EN to pad out the bottom border per frame.
module rowbuf_seq_ctrl
  import rowbuf_pkg::*;
#(
  parameter int  DATA_WIDTH   = 14,
  parameter int  IMAGE_WIDTH  = 640,
  parameter int  IMAGE_HEIGHT = 480,
  parameter int  WIN_COLS     = 49,
  parameter int  WIN_ROWS     = 3,
  localparam int CW = rb_width(IMAGE_WIDTH),
  localparam int RW = rb_width(IMAGE_HEIGHT + WIN_ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sof,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          shift_en,
  output logic          pad_sel,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          win_valid,
  output logic          win_last,
  output logic          sof_err,
  output logic          busy
);

  localparam logic [CW-1:0] COL_FULL = CW'(WIN_COLS - 1);
  localparam logic [RW-1:0] ROW_FULL = RW'(WIN_ROWS - 1);

  state_t        state;
  logic          accept;
  logic          restart;
  logic          win_hit;
  logic          eol;
  logic          eof;
  logic [CW-1:0] nxt_col;
  logic [RW-1:0] nxt_row;

  // Pad value is muxed in by the row buffers; only its width lives here.
  logic [DATA_WIDTH-1:0] unused_pad;
  assign unused_pad = {DATA_WIDTH{PAD_BIT}};

  assign in_ready = rst & out_ready & (state != FLUSH);
  assign accept   = in_valid & in_ready;
  assign restart  = accept & sof;
  assign busy     = (state != IDLE);
  assign win_hit  = (nxt_row >= ROW_FULL) && (nxt_col >= COL_FULL);

  always_comb begin
    shift_en = 1'b0;
    case (state)
      IDLE:      shift_en = restart;
      FILL, RUN: shift_en = accept;
`ifdef ROWBUF_CTRL_FLUSH_EN
      FLUSH:     shift_en = rst & out_ready;
`endif
      default:   shift_en = 1'b0;
    endcase
  end

  raster_counter #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT),
    .CW           (CW),
    .RW           (RW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (shift_en),
    .clr     (restart),
    .col     (col),
    .row     (row),
    .nxt_col (nxt_col),
    .nxt_row (nxt_row),
    .eol     (eol),
    .eof     (eof)
  );

`ifdef ROWBUF_CTRL_FLUSH_EN
  localparam logic [RW-1:0] PAD_END = RW'(IMAGE_HEIGHT + WIN_ROWS - 2);
  logic pad_q;
  logic flush_end;
  assign flush_end = eol && (nxt_row == PAD_END);
  assign pad_sel   = pad_q;
`else
  logic unused_eol;
  assign unused_eol = eol;
  assign pad_sel    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      sof_err   <= 1'b0;
`ifdef ROWBUF_CTRL_FLUSH_EN
      pad_q     <= 1'b0;
`endif
    end else begin
      win_valid <= shift_en & win_hit;
      win_last  <= 1'b0;
      sof_err   <= restart & (state != IDLE);
      case (state)
        IDLE: begin
          if (restart) state <= FILL;
        end
        FILL, RUN: begin
          if (restart) begin
            state <= FILL;
          end else if (shift_en) begin
            if (eof) begin
`ifdef ROWBUF_CTRL_FLUSH_EN
              state <= FLUSH;
              pad_q <= 1'b1;
`else
              state    <= IDLE;
              win_last <= win_hit;
`endif
            end else if (nxt_row >= ROW_FULL) begin
              state <= RUN;
            end
          end
        end
`ifdef ROWBUF_CTRL_FLUSH_EN
        FLUSH: begin
          if (shift_en && flush_end) begin
            state    <= IDLE;
            pad_q    <= 1'b0;
            win_last <= win_hit;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rowbuf_seq_ctrl.sv
// tb_rowbuf_seq_ctrl: directed bench for rowbuf_seq_ctrl
// on an 8x4 image with a 3x2 window.
module tb_rowbuf_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sof = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       shift_en;
  logic       pad_sel;
  logic [2:0] col;
  logic [2:0] row;
  logic       win_valid;
  logic       win_last;
  logic       sof_err;
  logic       busy;

  int tests = 0;
  int fails = 0;

  rowbuf_seq_ctrl #(
    .DATA_WIDTH   (14),
    .IMAGE_WIDTH  (8),
    .IMAGE_HEIGHT (4),
    .WIN_COLS     (3),
    .WIN_ROWS     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sof       (sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .shift_en  (shift_en),
    .pad_sel   (pad_sel),
    .col       (col),
    .row       (row),
    .win_valid (win_valid),
    .win_last  (win_last),
    .sof_err   (sof_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // Inputs change at the falling edge; registered outputs then
  // reflect the previous rising edge, combinational ones the new inputs.
  task automatic drive(input logic v, input logic s, input logic r);
    @(negedge clk);
    in_valid  = v;
    sof       = s;
    out_ready = r;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    sof = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    sof = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    tests++;
    if (shift_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_shift_en got %b want 0", shift_en);
    end
    tests++;
    if ({col, row} !== 6'd0) begin
      fails++;
      $display("FAIL reset_pos got col=%0d row=%0d want 0/0", col, row);
    end
    tests++;
    if ({win_valid, win_last, sof_err, pad_sel, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 00000",
               {win_valid, win_last, sof_err, pad_sel, busy});
    end
    in_valid = 1'b0;
    sof = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_full_frame(input string tag);
    int nv = 0;
    int nse = 0;
    int nlast = 0;
    int last_at = -1;
    int npad = 0;
`ifdef ROWBUF_CTRL_FLUSH_EN
    int nv_at_last = -1;
    for (int i = 0; i < 56; i++) begin
      drive(1'b1, i == 0, (i < 32) ? 1'b1 : ((i % 2) == 0));
      if (win_valid) nv++;
      if (win_last) begin
        nlast++;
        nv_at_last = nv;
      end
      if (shift_en) nse++;
      if (shift_en && pad_sel) npad++;
      if (i == 32) begin
        tests++;
        if (pad_sel !== 1'b1) begin
          fails++;
          $display("FAIL %s flush_start pad_sel got %b want 1", tag, pad_sel);
        end
      end
      if (pad_sel) begin
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s flush_in_ready cyc %0d got %b want 0",
                   tag, i, in_ready);
        end
      end
      if (!out_ready) begin
        tests++;
        if (shift_en !== 1'b0) begin
          fails++;
          $display("FAIL %s stalled_shift cyc %0d got %b want 0",
                   tag, i, shift_en);
        end
      end
    end
    tests++;
    if (npad != 8) begin
      fails++;
      $display("FAIL %s pad_beats got %0d want 8", tag, npad);
    end
    tests++;
    if (nse != 40) begin
      fails++;
      $display("FAIL %s shift_count got %0d want 40", tag, nse);
    end
    tests++;
    if (nv != 24) begin
      fails++;
      $display("FAIL %s win_valid_count got %0d want 24", tag, nv);
    end
    tests++;
    if (nlast != 1 || nv_at_last != 24) begin
      fails++;
      $display("FAIL %s win_last got n=%0d at_win=%0d want 1/24",
               tag, nlast, nv_at_last);
    end
    tests++;
    if ({busy, pad_sel} !== 2'b00) begin
      fails++;
      $display("FAIL %s end_idle busy/pad got %b want 00", tag, {busy, pad_sel});
    end
    tests++;
    if (col !== 3'd7 || row !== 3'd4) begin
      fails++;
      $display("FAIL %s end_pos got %0d/%0d want 7/4", tag, col, row);
    end
`else
    for (int i = 0; i < 44; i++) begin
      drive(1'b1, i == 0, (i < 32) ? 1'b1 : ((i % 2) == 0));
      if (win_valid) nv++;
      if (win_last) begin
        nlast++;
        last_at = i;
      end
      if (shift_en) nse++;
      if (pad_sel) npad++;
      if (i == 32) begin
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL %s idle_after_frame busy got %b want 0", tag, busy);
        end
      end
    end
    tests++;
    if (nse != 32) begin
      fails++;
      $display("FAIL %s shift_count got %0d want 32", tag, nse);
    end
    tests++;
    if (nv != 18) begin
      fails++;
      $display("FAIL %s win_valid_count got %0d want 18", tag, nv);
    end
    tests++;
    if (nlast != 1 || last_at != 32) begin
      fails++;
      $display("FAIL %s win_last got n=%0d at=%0d want 1/32",
               tag, nlast, last_at);
    end
    tests++;
    if (npad != 0) begin
      fails++;
      $display("FAIL %s pad_sel_cycles got %0d want 0", tag, npad);
    end
    tests++;
    if (col !== 3'd7 || row !== 3'd3) begin
      fails++;
      $display("FAIL %s end_pos got %0d/%0d want 7/3", tag, col, row);
    end
`endif
  endtask

  task automatic test_stall();
    apply_reset();
    for (int i = 0; i < 13; i++) drive(1'b1, i == 0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 1'b0, 1'b0);
      tests++;
      if (in_ready !== 1'b0 || shift_en !== 1'b0) begin
        fails++;
        $display("FAIL stall_hs cyc %0d in_ready=%b shift_en=%b want 0/0",
                 j, in_ready, shift_en);
      end
      tests++;
      if (col !== 3'd4 || row !== 3'd1) begin
        fails++;
        $display("FAIL stall_pos cyc %0d got %0d/%0d want 4/1", j, col, row);
      end
      if (j > 0) begin
        tests++;
        if (win_valid !== 1'b0) begin
          fails++;
          $display("FAIL stall_win cyc %0d got %b want 0", j, win_valid);
        end
      end
    end
    drive(1'b1, 1'b0, 1'b1);
    tests++;
    if (shift_en !== 1'b1) begin
      fails++;
      $display("FAIL resume_shift got %b want 1", shift_en);
    end
    drive(1'b0, 1'b0, 1'b1);
    tests++;
    if (col !== 3'd5 || row !== 3'd1 || win_valid !== 1'b1) begin
      fails++;
      $display("FAIL resume_pos got %0d/%0d win=%b want 5/1 win=1",
               col, row, win_valid);
    end
  endtask

  task automatic test_sof_restart();
    apply_reset();
    for (int i = 0; i < 12; i++) drive(1'b1, i == 0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    tests++;
    if (shift_en !== 1'b1) begin
      fails++;
      $display("FAIL restart_shift got %b want 1", shift_en);
    end
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 1'b0, 1'b1);
      if (k == 1) begin
        tests++;
        if (sof_err !== 1'b1 || col !== 3'd0 || row !== 3'd0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL restart_state err=%b pos=%0d/%0d busy=%b want 1 0/0 1",
                   sof_err, col, row, busy);
        end
      end
      if (k == 2) begin
        tests++;
        if (sof_err !== 1'b0) begin
          fails++;
          $display("FAIL sof_err_pulse got %b want 0", sof_err);
        end
      end
      tests++;
      if (win_valid !== ((k - 1) >= 10)) begin
        fails++;
        $display("FAIL restart_win pix %0d got %b want %b",
                 k - 1, win_valid, (k - 1) >= 10);
      end
    end
  endtask

  task automatic test_idle_drop();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      tests++;
      if (in_ready !== 1'b1 || shift_en !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_drop beat %0d rdy=%b se=%b busy=%b want 1/0/0",
                 i, in_ready, shift_en, busy);
      end
      tests++;
      if (col !== 3'd0 || row !== 3'd0) begin
        fails++;
        $display("FAIL idle_pos beat %0d got %0d/%0d want 0/0", i, col, row);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, i == 0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    #1;
    tests++;
    if (col !== 3'd3 || row !== 3'd2 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midrun_pos got %0d/%0d busy=%b want 3/2 1", col, row, busy);
    end
    tests++;
    if (in_ready !== 1'b0 || shift_en !== 1'b0) begin
      fails++;
      $display("FAIL midrun_rst_hs rdy=%b se=%b want 0/0", in_ready, shift_en);
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    tests++;
    if ({col, row} !== 6'd0 || {win_valid, win_last, sof_err, pad_sel, busy} !== 5'b0) begin
      fails++;
      $display("FAIL midrun_cleared pos=%0d/%0d flags=%b want 0/0 00000",
               col, row, {win_valid, win_last, sof_err, pad_sel, busy});
    end
    test_full_frame("after_reset");
  endtask

  initial begin
    test_reset();
    test_full_frame("frame");
    test_stall();
    test_sof_restart();
    test_idle_drop();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
